// File: rtl/tea_pkg.sv
// Shared constants and FSM encoding for the TEA round controller.
package tea_pkg;

    localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;
    localparam logic [31:0] DEC_SUM_INIT  = 32'hC6EF3720;
    localparam int unsigned NUM_ROUNDS    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod33next.sv
// Next-state logic for a 6-bit counter cycling 0..32 and wrapping back to 0.
module mod33next
    import tea_pkg::*;
(
    input  logic [5:0] cur,
    output logic [5:0] nxt
);

    // wrap after the terminal value NUM_ROUNDS
    always_comb begin
        nxt = 6'd0;
        if (cur >= 6'(NUM_ROUNDS)) begin
            nxt = 6'd0;
        end else begin
            nxt = cur + 6'd1;
        end
    end

endmodule

// File: rtl/tea_round_ctrl.sv
// TEA round sequencer: steps a round index and key-schedule sum through 32 rounds
// for encrypt or decrypt, with abort and a one-cycle completion pulse.
module tea_round_ctrl
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic        abort,
    output logic        load,
    output logic        busy,
    output logic        round_en,
    output logic [5:0]  round,
    output logic [31:0] sum,
    output logic        done
);

    // decrypt starts from DELTA*32 and walks the schedule backwards
    localparam logic [31:0] DEC_INIT = (DELTA == DELTA_DEFAULT) ? DEC_SUM_INIT
                                                                : 32'(DELTA * NUM_ROUNDS);

    state_t      state_r;
    logic [5:0]  round_r;
    logic [5:0]  round_nxt_s;
    logic [31:0] sum_r;
    logic        mode_r;
    logic        busy_r;
    logic        round_en_r;
    logic        done_r;
    logic        load_s;

    mod33next u_mod33next (
        .cur (round_r),
        .nxt (round_nxt_s)
    );

    // start acceptance; abort wins and reset masks it immediately
    always_comb begin
        load_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE) && start && !abort) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // controller FSM with registered round, sum and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            round_r    <= 6'd0;
            sum_r      <= 32'd0;
            mode_r     <= 1'b0;
            busy_r     <= 1'b0;
            round_en_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r    <= ST_RUN;
                        round_r    <= 6'd0;
                        sum_r      <= decrypt ? DEC_INIT : DELTA;
                        mode_r     <= decrypt;
                        busy_r     <= 1'b1;
                        round_en_r <= 1'b1;
                        done_r     <= 1'b0;
                    end else begin
                        round_r    <= 6'd0;
                        sum_r      <= 32'd0;
                        busy_r     <= 1'b0;
                        round_en_r <= 1'b0;
                        done_r     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r    <= ST_IDLE;
                        round_r    <= 6'd0;
                        sum_r      <= 32'd0;
                        busy_r     <= 1'b0;
                        round_en_r <= 1'b0;
                        done_r     <= 1'b0;
                    end else begin
                        round_r <= round_nxt_s;
                        sum_r   <= mode_r ? (sum_r - DELTA) : (sum_r + DELTA);
                        if (round_nxt_s[5]) begin
                            state_r    <= ST_DONE;
                            round_en_r <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            state_r    <= ST_RUN;
                            round_en_r <= 1'b1;
                            done_r     <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    round_r    <= 6'd0;
                    sum_r      <= 32'd0;
                    busy_r     <= 1'b0;
                    round_en_r <= 1'b0;
                    done_r     <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    round_r    <= 6'd0;
                    sum_r      <= 32'd0;
                    busy_r     <= 1'b0;
                    round_en_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign load     = load_s;
    assign busy     = busy_r;
    assign round_en = round_en_r;
    assign round    = round_r;
    assign sum      = sum_r;
    assign done     = done_r;

endmodule

// File: tb/tb_tea_round_ctrl.sv
// Scoreboard bench for tea_round_ctrl: stimulus queues expected LOAD/round/DONE
// events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_tea_round_ctrl;

    localparam logic [31:0] DELTA_C = 32'h9E3779B9;
    localparam logic [1:0]  K_LOAD  = 2'd0;
    localparam logic [1:0]  K_ROUND = 2'd1;
    localparam logic [1:0]  K_DONE  = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [5:0]  rnd;
        logic [31:0] sum;
        logic        busy;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        abort = 1'b0;
    logic        load;
    logic        busy;
    logic        round_en;
    logic [5:0]  round;
    logic [31:0] sum;
    logic        done;

    int total = 0;
    int bad   = 0;
    ev_t exp_q[$];

    tea_round_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .abort    (abort),
        .load     (load),
        .busy     (busy),
        .round_en (round_en),
        .round    (round),
        .sum      (sum),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // expected event stream for one accepted START; sums from the closed form DELTA*(k+1) / DELTA*(32-k)
    task automatic push_run(input logic dec, input int n_rounds, input bit with_done);
        ev_t e;
        e.kind = K_LOAD; e.rnd = 6'd0; e.sum = 32'd0; e.busy = 1'b0;
        exp_q.push_back(e);
        for (int k = 0; k < n_rounds; k++) begin
            e.kind = K_ROUND;
            e.rnd  = 6'(k);
            e.sum  = dec ? 32'(DELTA_C * 32'(32 - k)) : 32'(DELTA_C * 32'(k + 1));
            e.busy = 1'b1;
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.kind = K_DONE; e.rnd = 6'd0; e.sum = 32'd0; e.busy = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_round"}, {26'd0, round}, 32'd0);
        chk({name, "_sum"}, sum, 32'd0);
        chk({name, "_flags"}, {29'd0, round_en, done, load}, 32'd0);
    endtask

    // monitor: every presented LOAD / round strobe / DONE must match the queue head
    always @(negedge clk) begin
        ev_t e;
        logic [1:0] obs;
        bit ok;
        if (rst_n && (load || round_en || done)) begin
            total++;
            obs = load ? K_LOAD : (round_en ? K_ROUND : K_DONE);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: load=%b round_en=%b done=%b round=%0d sum=%h, expected no event",
                         load, round_en, done, round, sum);
            end else begin
                e  = exp_q.pop_front();
                ok = ($countones({load, round_en, done}) == 1) && (obs == e.kind) && (busy == e.busy);
                if (e.kind == K_ROUND) ok = ok && (round == e.rnd) && (sum == e.sum);
                if (e.kind == K_LOAD)  ok = ok && (round == 6'd0) && (sum == 32'd0);
                if (!ok) begin
                    bad++;
                    $display("FAIL event: got kind=%0d busy=%b round=%0d sum=%h, expected kind=%0d busy=%b round=%0d sum=%h",
                             obs, busy, round, sum, e.kind, e.busy, e.rnd, e.sum);
                end
            end
        end
    end

    initial begin
        // reset state
        #2;
        chk_idle("reset");
        tick();
        // release and start on the same edge window: accepted at the first rising edge
        rst_n = 1'b1; start = 1'b1; decrypt = 1'b0;
        push_run(1'b0, 32, 1'b1);
        #1;
        chk("enc_load", {31'd0, load}, 32'd1);
        tick();
        start = 1'b0;
        chk("enc_r0_round", {26'd0, round}, 32'd0);
        chk("enc_r0_sum", sum, 32'h9E3779B9);
        tick();
        chk("enc_r1_round", {26'd0, round}, 32'd1);
        chk("enc_r1_sum", sum, 32'h3C6EF372);
        repeat (30) tick();
        chk("enc_r31_round", {26'd0, round}, 32'd31);
        chk("enc_r31_sum", sum, 32'hC6EF3720);
        tick();
        chk("enc_done", {29'd0, done, round_en, busy}, 32'b101);
        tick();
        chk_idle("enc_after");

        // decrypt run
        start = 1'b1; decrypt = 1'b1;
        push_run(1'b1, 32, 1'b1);
        tick();
        start = 1'b0; decrypt = 1'b0;
        chk("dec_r0_sum", sum, 32'hC6EF3720);
        repeat (31) tick();
        chk("dec_r31_sum", sum, 32'h9E3779B9);
        repeat (2) tick();
        chk_idle("dec_after");

        // START pulses and DECRYPT toggles while busy have no effect
        start = 1'b1; decrypt = 1'b0;
        push_run(1'b0, 32, 1'b1);
        tick();
        for (int i = 0; i < 32; i++) begin
            start   = i[0];
            decrypt = i[1];
            tick();
        end
        start = 1'b0; decrypt = 1'b0;
        tick();
        chk_idle("busy_after");

        // abort at round 10
        start = 1'b1;
        push_run(1'b0, 11, 1'b0);
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("abort_at_round", {26'd0, round}, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort_after");
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        start = 1'b1;
        push_run(1'b0, 32, 1'b1);
        tick();
        start = 1'b0;
        chk("restart_round", {26'd0, round}, 32'd0);
        repeat (33) tick();

        // asynchronous reset at round 20
        start = 1'b1;
        push_run(1'b0, 21, 1'b0);
        tick();
        start = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        tick();
        rst_n = 1'b1; start = 1'b1;
        push_run(1'b0, 32, 1'b1);
        tick();
        start = 1'b0;
        repeat (33) tick();

        // START with ABORT in IDLE is refused
        start = 1'b1; abort = 1'b1;
        #1;
        chk("start_abort_load", {31'd0, load}, 32'd0);
        tick();
        chk("start_abort_busy", {31'd0, busy}, 32'd0);

        // START held high: accepted at T and T+34 only
        abort = 1'b0;
        push_run(1'b0, 32, 1'b1);
        tick();
        repeat (33) tick();
        chk("held_reaccept", {31'd0, load}, 32'd1);
        push_run(1'b0, 32, 1'b1);
        tick();
        start = 1'b0;
        repeat (33) tick();
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tea_round_ctrl.md
TEA_ROUND_CTRL -- requirements
Module: tea_round_ctrl

Interface
REQ-001 The block SHALL have parameter DELTA, default 32'h9E3779B9, meaning the TEA key-schedule constant added or subtracted once per round.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: request one 32-round operation; accepted only in IDLE.
REQ-005 The block SHALL have port DECRYPT, input, 1 bit: mode select, 0 = encrypt, 1 = decrypt; sampled only when START is accepted.
REQ-006 The block SHALL have port ABORT, input, 1 bit: cancel any operation in progress.
REQ-007 The block SHALL have port LOAD, output, 1 bit: high in the cycle START is accepted, so the datapath captures its plaintext and key.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high in RUN and DONE.
REQ-009 The block SHALL have port ROUND_EN, output, 1 bit: datapath round strobe, high exactly in RUN.
REQ-010 The block SHALL have port ROUND, output, 6 bits: current round index, 0..31 in RUN.
REQ-011 The block SHALL have port SUM, output, 32 bits: sum value the datapath uses in the current round.
REQ-012 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when the result is valid.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with START=1 and ABORT=0, the block SHALL assert LOAD combinationally, load the round register with 0, load SUM with DELTA (encrypt) or DELTA*32 mod 2^32 = 32'hC6EF3720 (decrypt), latch the mode, and move to RUN.
REQ-015 In RUN, each cycle the round register SHALL advance by the mod-33 sequence 0,1,...,31,32,0.
REQ-016 In RUN, each cycle SUM SHALL become SUM+DELTA (encrypt) or SUM-DELTA (decrypt), with 32-bit wrap-around.
REQ-017 In RUN, SUM SHALL equal DELTA*(ROUND+1) mod 2^32 when encrypting and DELTA*(32-ROUND) mod 2^32 when decrypting.
REQ-018 When the round register reaches 32 (bit 5 set), the block SHALL be in DONE with ROUND_EN=0 and DONE=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency: START accepted at cycle T SHALL give ROUND_EN high in cycles T+1..T+32 (32 cycles) and DONE high in cycle T+33.
REQ-020 The earliest next START SHALL be accepted at T+34, i.e. in IDLE.
REQ-021 START while BUSY=1 SHALL be ignored; DECRYPT changes while BUSY=1 SHALL have no effect.
REQ-022 ABORT=1 in RUN or DONE SHALL force IDLE on the next edge with no DONE pulse, and the round register and SUM SHALL clear to 0.
REQ-023 ABORT=1 together with START=1 in IDLE SHALL take precedence: START is not accepted and LOAD stays 0.
REQ-024 In IDLE, ROUND and SUM SHALL read 0.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, round register 0, SUM 0, latched mode 0, and LOAD, BUSY, ROUND_EN and DONE low.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no DONE pulse.
REQ-027 After RST_N deasserts, the first START SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package tea_pkg SHALL hold DELTA_DEFAULT, DEC_SUM_INIT (32'hC6EF3720), NUM_ROUNDS (32) and the FSM state encoding.
REQ-029 The round-register next-state logic SHALL be the team's existing 6-bit mod-33 next-state block mod33next, instantiated as the block's only sub-module.
REQ-030 The block SHALL contain no other sub-modules.

Verification
REQ-031 Encrypt run: START=1, DECRYPT=0 at T -> LOAD=1 at T; ROUND=0, SUM=9E3779B9 at T+1; ROUND=1, SUM=3C6EF372 at T+2; ROUND=31, SUM=C6EF3720 at T+32; DONE at T+33 only.
REQ-032 Decrypt run: START=1, DECRYPT=1 -> SUM=C6EF3720 at ROUND 0, SUM=9E3779B9 at ROUND 31; DONE after exactly 32 ROUND_EN cycles.
REQ-033 Busy start and mode change: START pulses and DECRYPT toggles during RUN -> no LOAD, SUM sequence unchanged, exactly one DONE.
REQ-034 Abort: ABORT=1 at ROUND=10 -> IDLE next cycle, BUSY=0, ROUND=0, SUM=0, no DONE; a following START restarts at ROUND 0.
REQ-035 Reset mid-run: RST_N=0 asynchronously at ROUND=20 -> all outputs 0 immediately; after release, START gives the full 32-round sequence.
REQ-036 Simultaneous inputs and back-to-back: START=1 with ABORT=1 in IDLE -> not accepted; START held high continuously -> accepted at T and T+34 only.
